hazard_controller: RTL
======================

// Module: hazard_controller
// PURPOSE
//  Pipeline scheduler for the 5-stage MIPS core. Drives the execute-stage operand forwarding muxes
//  and the decode-stage branch-compare forwarding. Stalls fetch/decode and flushes execute on
//  load-use, branch/jr and mult/div hazards. Owns a multi-cycle HI/LO busy counter for mult/div.
//  Sits beside the F/D/E/M/W stages; all its outputs feed stage pipeline-register enables/clears and mux selects.
// PARAMETERS
//  MUL_LATENCY  4   cycles HI/LO stays busy after a mult/multu leaves E (>=1)
//  DIV_LATENCY  32  cycles HI/LO stays busy after a div/divu leaves E (>=MUL_LATENCY)
// PORTS
//  clk_i          in   1  clock; one clock domain
//  rst_i          in   1  reset, synchronous, active-high
//  rs_d_i, rt_d_i in   5  source regs of instruction in D
//  use_rs_d_i     in   1  D instruction reads rs (suppresses false hazards)
//  use_rt_d_i     in   1  D instruction reads rt
//  branch_d_i     in   1  D holds beq/bne/jr (compares/reads regs in D)
//  md_start_d_i   in   1  D holds mult/div
//  md_read_d_i    in   1  D holds mfhi/mflo/mthi/mtlo
//  rs_e_i, rt_e_i in   5  source regs of instruction in E
//  write_reg_e_i  in   5  dest reg in E
//  reg_write_e_i, mem_to_reg_e_i  in  1  E control
//  md_start_e_i   in   1  E holds mult/div (valid, not a bubble)
//  md_op_e_i      in   1  0 = mult family, 1 = div family
//  write_reg_m_i  in   5  dest reg in M
//  reg_write_m_i, mem_to_reg_m_i  in  1  M control
//  write_reg_w_i  in   5  dest reg in W
//  reg_write_w_i  in   1  W control
//  forward_a_d_o, forward_b_d_o   out  1  D compare operand: 1 = alu_out_m, 0 = regfile
//  forward_a_e_o, forward_b_e_o   out  2  E operand select (fwd_sel_e_t)
//  stall_f_o, stall_d_o           out  1  hold PC / hold F->D register
//  flush_e_o                      out  1  sync-clear D->E register (insert bubble)
//  md_busy_o                      out  1  HI/LO unit busy
// BEHAVIOUR
//  - Forward E (combinational), per operand X in {rs_e, rt_e}; reg $0 never forwarded:
//    X!=0 && reg_write_m_i && write_reg_m_i==X -> FWD_M (2'b10, alu_out_m)
//    elif X!=0 && reg_write_w_i && write_reg_w_i==X -> FWD_W (2'b01, result_w); else FWD_RF (2'b00).
//    M has priority over W. 2'b11 is never driven.
//  - Forward D: forward_a_d_o = rs_d_i!=0 && reg_write_m_i && write_reg_m_i==rs_d_i; same for rt.
//  - hit_e(r) = reg_write_e_i && write_reg_e_i!=0 && write_reg_e_i==r; hit_m likewise with M signals.
//  - lw_stall = mem_to_reg_e_i && ((use_rs_d_i && hit_e(rs_d_i)) || (use_rt_d_i && hit_e(rt_d_i))).
//  - br_stall = branch_d_i && for any used src r: hit_e(r) || (mem_to_reg_m_i && hit_m(r)).
//  - md_stall = (md_busy_o || md_start_e_i) && (md_read_d_i || md_start_d_i).
//  - stall = lw_stall | br_stall | md_stall; stall_f_o = stall_d_o = flush_e_o = stall.
//  - Busy counter cnt, width $clog2(DIV_LATENCY+1):
//    - rst_i: cnt <= 0.
//    - elif md_start_e_i: cnt <= md_op_e_i ? DIV_LATENCY : MUL_LATENCY.
//    - elif cnt!=0: cnt <= cnt-1.
//    - md_busy_o = (cnt!=0): high exactly LAT cycles, starting the cycle after md_start_e_i.
//    - md_start_e_i while cnt!=0 is impossible by construction (md_stall); assertion flags it.
//      Reload wins if it occurs.
//  - Reset: while rst_i, all stall/flush/forward outputs forced 0, md_busy_o 0 the cycle after.
//    Reset mid mult/div aborts it; cnt cleared.
//  - Latency: forwarding/stall paths are purely combinational, zero-cycle. Only cnt is registered.
// STRUCTURE
//  - pipeline_pkg: typedef enum logic [1:0] {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10} fwd_sel_e_t.
//    Also holds MUL_LATENCY_DEF and DIV_LATENCY_DEF constants.
//  - Sub-module md_busy_counter: load value, load enable, busy flag, parameterised width.
//  - Remainder of the block is flat combinational logic in this module.
// TESTING
//  1 add $3 in M, add $3 in W, E rs_e=3 rt_e=3 -> forward_a_e=forward_b_e=2'b10; kill M write -> 2'b01.
//  2 rs_e=0 with write_reg_m=0, reg_write_m=1 -> forward_a_e=2'b00; forward_a_d=0.
//  3 lw $5 in E, D add uses rt=5 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle.
//    Next cycle forward_b_e=2'b10 is irrelevant (mem path); forward_b_e=2'b01 once lw reaches W.
//  4 beq in D on $7, add $7 in E -> 1 stall. lw $7 in E -> 2 consecutive stalls. Then forward_a_d=0.
//  5 div in E (md_op=1), mfhi in D -> stall on cycles 0..32 (33 cycles). md_busy high cycles 1..32.
//    Mult: stall 5 cycles, md_busy 4.
//  6 rst_i asserted at cycle 10 of a div -> md_busy_o=0 next cycle, no stall. A new mult is accepted.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forward-select encoding, default mult/div latencies and small register-match helpers.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e_t;

  localparam int MUL_LATENCY_DEF = 4;
  localparam int DIV_LATENCY_DEF = 32;

  // Register $0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic reg_hit(input logic rw, input logic [4:0] wr, input logic [4:0] r);
    return rw && (wr != 5'd0) && (wr == r);
  endfunction

  // M is the younger producer, so it takes priority over W.
  function automatic fwd_sel_e_t fwd_sel(input logic [4:0] src,
                                         input logic rw_m, input logic [4:0] wr_m,
                                         input logic rw_w, input logic [4:0] wr_w);
    fwd_sel_e_t sel;
    sel = FWD_RF;
    if (reg_hit(rw_m, wr_m, src))      sel = FWD_M;
    else if (reg_hit(rw_w, wr_w, src)) sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle of pipeline-stage hazard inputs and the forward/stall/flush controls returned to the stages.
// The pipeline side (master) drives stage info; the hazard controller (slave) drives the controls.
interface hazard_controller_if;
  import pipeline_pkg::*;

  logic [4:0] rs_d_i;
  logic [4:0] rt_d_i;
  logic       use_rs_d_i;
  logic       use_rt_d_i;
  logic       branch_d_i;
  logic       md_start_d_i;
  logic       md_read_d_i;
  logic [4:0] rs_e_i;
  logic [4:0] rt_e_i;
  logic [4:0] write_reg_e_i;
  logic       reg_write_e_i;
  logic       mem_to_reg_e_i;
  logic       md_start_e_i;
  logic       md_op_e_i;
  logic [4:0] write_reg_m_i;
  logic       reg_write_m_i;
  logic       mem_to_reg_m_i;
  logic [4:0] write_reg_w_i;
  logic       reg_write_w_i;

  logic       forward_a_d_o;
  logic       forward_b_d_o;
  fwd_sel_e_t forward_a_e_o;
  fwd_sel_e_t forward_b_e_o;
  logic       stall_f_o;
  logic       stall_d_o;
  logic       flush_e_o;
  logic       md_busy_o;

  modport master (
    output rs_d_i, rt_d_i, use_rs_d_i, use_rt_d_i, branch_d_i, md_start_d_i, md_read_d_i,
           rs_e_i, rt_e_i, write_reg_e_i, reg_write_e_i, mem_to_reg_e_i, md_start_e_i, md_op_e_i,
           write_reg_m_i, reg_write_m_i, mem_to_reg_m_i, write_reg_w_i, reg_write_w_i,
    input  forward_a_d_o, forward_b_d_o, forward_a_e_o, forward_b_e_o,
           stall_f_o, stall_d_o, flush_e_o, md_busy_o
  );

  modport slave (
    input  rs_d_i, rt_d_i, use_rs_d_i, use_rt_d_i, branch_d_i, md_start_d_i, md_read_d_i,
           rs_e_i, rt_e_i, write_reg_e_i, reg_write_e_i, mem_to_reg_e_i, md_start_e_i, md_op_e_i,
           write_reg_m_i, reg_write_m_i, mem_to_reg_m_i, write_reg_w_i, reg_write_w_i,
    output forward_a_d_o, forward_b_d_o, forward_a_e_o, forward_b_e_o,
           stall_f_o, stall_d_o, flush_e_o, md_busy_o
  );

endinterface

// File: rtl/md_busy_counter.sv
// Down-counter tracking how long the HI/LO unit stays busy after a mult/div leaves execute.
// A load always wins over the decrement.
module md_busy_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             busy_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_en_i)           cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage MIPS pipeline: operand forwarding selects, load-use,
// branch and mult/div stalls, plus the HI/LO busy counter. All paths except the counter are combinational.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
  input logic                clk_i,
  input logic                rst_i,
  hazard_controller_if.slave hz
);

  localparam int CNT_W = $clog2(DIV_LATENCY + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY);

  logic md_busy;
  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic stall;
  logic br_dep_rs;
  logic br_dep_rt;

  md_busy_counter #(.WIDTH(CNT_W)) u_md_busy_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_en_i  (hz.md_start_e_i),
    .load_val_i (hz.md_op_e_i ? DIV_LOAD : MUL_LOAD),
    .busy_o     (md_busy)
  );

  always_comb begin
    lw_stall = hz.mem_to_reg_e_i &&
               ((hz.use_rs_d_i && reg_hit(hz.reg_write_e_i, hz.write_reg_e_i, hz.rs_d_i)) ||
                (hz.use_rt_d_i && reg_hit(hz.reg_write_e_i, hz.write_reg_e_i, hz.rt_d_i)));

    // A branch compares in D, so it waits for any E producer and for a load still in M.
    br_dep_rs = reg_hit(hz.reg_write_e_i, hz.write_reg_e_i, hz.rs_d_i) ||
                (hz.mem_to_reg_m_i && reg_hit(hz.reg_write_m_i, hz.write_reg_m_i, hz.rs_d_i));
    br_dep_rt = reg_hit(hz.reg_write_e_i, hz.write_reg_e_i, hz.rt_d_i) ||
                (hz.mem_to_reg_m_i && reg_hit(hz.reg_write_m_i, hz.write_reg_m_i, hz.rt_d_i));
    br_stall  = hz.branch_d_i && ((hz.use_rs_d_i && br_dep_rs) || (hz.use_rt_d_i && br_dep_rt));

    md_stall  = (md_busy || hz.md_start_e_i) && (hz.md_read_d_i || hz.md_start_d_i);
    stall     = !rst_i && (lw_stall || br_stall || md_stall);

    hz.stall_f_o = stall;
    hz.stall_d_o = stall;
    hz.flush_e_o = stall;
    hz.md_busy_o = md_busy;

    hz.forward_a_d_o = 1'b0;
    hz.forward_b_d_o = 1'b0;
    hz.forward_a_e_o = FWD_RF;
    hz.forward_b_e_o = FWD_RF;
    if (!rst_i) begin
      hz.forward_a_d_o = reg_hit(hz.reg_write_m_i, hz.write_reg_m_i, hz.rs_d_i);
      hz.forward_b_d_o = reg_hit(hz.reg_write_m_i, hz.write_reg_m_i, hz.rt_d_i);
      hz.forward_a_e_o = fwd_sel(hz.rs_e_i, hz.reg_write_m_i, hz.write_reg_m_i,
                                 hz.reg_write_w_i, hz.write_reg_w_i);
      hz.forward_b_e_o = fwd_sel(hz.rt_e_i, hz.reg_write_m_i, hz.write_reg_m_i,
                                 hz.reg_write_w_i, hz.write_reg_w_i);
    end
  end

  // md_stall keeps a second mult/div out of E while the unit is busy.
  md_start_while_busy_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(hz.md_start_e_i && md_busy));

endmodule
